apb_slave_regfile: RTL



---
 rtl/apb_slv_pkg.sv | 35 +++
 rtl/apb_slave_regfile.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types, register map constants and decode helpers for the APB register-file completer.
// The decode function is the single place that decides whether a setup phase is an error.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int CTRL_IDX      = 0;
    localparam int STATUS_IDX    = 1;
    localparam int FIRST_SCRATCH = 2;

    localparam int WAIT_LSB   = 0;
    localparam int WAIT_W     = 4;
    localparam int IRQ_EN_BIT = 8;
    localparam int CLR_BIT    = 9;

    // Address is passed zero-extended to 32 bits so the helper is independent of ADDR_WIDTH.
    function automatic logic decode_err(input logic [31:0] byte_addr,
                                        input logic        write,
                                        input logic [31:0] num_regs);
        logic [31:0] idx;
        idx = {2'b00, byte_addr[31:2]};
        return (byte_addr[1:0] != 2'b00)
            || (idx >= num_regs)
            || (write && (idx == 32'(STATUS_IDX)));
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// APB completer with a CTRL / STATUS / scratch register bank, programmable wait states and
// saturating transfer/error counters that drive a level error interrupt.
module apb_slave_regfile #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int RESET_WAIT = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  irq_o
);
    import apb_slv_pkg::*;

    localparam int IDX_W = ADDR_WIDTH - 2;

    state_t                 state;
    logic [WAIT_W-1:0]      cnt;
    logic [IDX_W-1:0]       lat_idx;
    logic                   lat_write;
    logic                   lat_err;
    logic [DATA_WIDTH-1:0]  lat_wdata;

    logic [WAIT_W-1:0]      ctrl_wait;
    logic                   irq_en;
    logic [15:0]            xfer_cnt;
    logic [15:0]            err_cnt;
    logic [DATA_WIDTH-1:0]  scratch [FIRST_SCRATCH:NUM_REGS-1];

    logic [IDX_W-1:0]       setup_idx;
    logic                   setup_err;
    logic                   commit_ctrl_clr;

    assign setup_idx = paddr[ADDR_WIDTH-1:2];
    assign setup_err = decode_err(32'(paddr), pwrite, 32'(NUM_REGS));
    assign commit_ctrl_clr = !lat_err && lat_write && (lat_idx == IDX_W'(CTRL_IDX))
                             && lat_wdata[CLR_BIT];

    function automatic logic [DATA_WIDTH-1:0] reg_read(input logic [IDX_W-1:0] idx);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        if (idx == IDX_W'(CTRL_IDX)) begin
            v[WAIT_LSB +: WAIT_W] = ctrl_wait;
            v[IRQ_EN_BIT]         = irq_en;
        end else if (idx == IDX_W'(STATUS_IDX)) begin
            v = {err_cnt, xfer_cnt};
        end else begin
            for (int i = FIRST_SCRATCH; i < NUM_REGS; i++) begin
                if (idx == IDX_W'(i)) v = scratch[i];
            end
        end
        return v;
    endfunction

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= '0;
            ctrl_wait <= WAIT_W'(RESET_WAIT);
            irq_en    <= 1'b0;
            xfer_cnt  <= '0;
            err_cnt   <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
            irq_o     <= 1'b0;
            for (int i = FIRST_SCRATCH; i < NUM_REGS; i++) scratch[i] <= '0;
        end else begin
            irq_o <= irq_en && (err_cnt != 16'd0);
            case (state)
                IDLE: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                    if (pselx && !penable) begin
                        lat_idx   <= setup_idx;
                        lat_write <= pwrite;
                        lat_wdata <= pwdata;
                        lat_err   <= setup_err;
                        cnt       <= ctrl_wait;
                        if (ctrl_wait == '0) begin
                            state   <= READY;
                            pready  <= 1'b1;
                            pslverr <= setup_err;
                            prdata  <= (setup_err || pwrite) ? '0 : reg_read(setup_idx);
                        end else begin
                            state <= WAIT;
                        end
                    end else if (pselx && penable) begin
                        // Access phase without a setup: answer at once with an error.
                        lat_err   <= 1'b1;
                        lat_write <= pwrite;
                        state     <= READY;
                        pready    <= 1'b1;
                        pslverr   <= 1'b1;
                        prdata    <= '0;
                    end
                end
                WAIT: begin
                    if (!pselx) begin
                        state <= IDLE;
                    end else if (cnt == WAIT_W'(1)) begin
                        state   <= READY;
                        pready  <= 1'b1;
                        pslverr <= lat_err;
                        prdata  <= (lat_err || lat_write) ? '0 : reg_read(lat_idx);
                    end else begin
                        cnt <= cnt - WAIT_W'(1);
                    end
                end
                READY: begin
                    state   <= IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                    if (!lat_err && lat_write) begin
                        if (lat_idx == IDX_W'(CTRL_IDX)) begin
                            ctrl_wait <= lat_wdata[WAIT_LSB +: WAIT_W];
                            irq_en    <= lat_wdata[IRQ_EN_BIT];
                        end
                        for (int i = FIRST_SCRATCH; i < NUM_REGS; i++) begin
                            if (lat_idx == IDX_W'(i)) scratch[i] <= lat_wdata;
                        end
                    end
                    // A clear in the same cycle as the increment leaves the counters at zero.
                    if (commit_ctrl_clr) begin
                        xfer_cnt <= '0;
                        err_cnt  <= '0;
                    end else begin
                        xfer_cnt <= sat_inc(xfer_cnt);
                        if (lat_err) err_cnt <= sat_inc(err_cnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
